// File: rtl/vblank_update_scheduler.sv
// vblank_update_scheduler
//   Runs one pass of game-object state updates per video frame, inside
//   vertical blanking. A falling edge on vsync starts the pass; objects are
//   granted one at a time with a req/ack handshake, each request bounded by
//   TIMEOUT cycles. When the last object is done, commit pulses so the drawing
//   side swaps to the new positions before the next visible frame.
// Ports
//   real100clock  system clock, rising edge
//   resetN        synchronous reset, active low
//   vsync         VGA vsync (active low); falling edge starts a pass
//   enable        0: new frame starts are ignored; a running pass completes
//   updAck        per-object done; only the active object's bit is used
//   clrFlags      1-cycle pulse clearing overrun and timeoutMask
//   updReq        one-hot (or zero) registered update request
//   commit        1-cycle pulse after all objects are processed
//   busy          high from the cycle after start through the commit cycle
//   frameCount    completed passes, wraps to 0
//   timeoutMask   sticky per-object timeout flags
//   overrun       sticky: a frame start arrived while a pass was running
module vblank_update_scheduler #(
  parameter int NUM_OBJ = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 16
) (
  input  logic               real100clock,
  input  logic               resetN,
  input  logic               vsync,
  input  logic               enable,
  input  logic [NUM_OBJ-1:0] updAck,
  input  logic               clrFlags,
  output logic [NUM_OBJ-1:0] updReq,
  output logic               commit,
  output logic               busy,
  output logic [CNT_W-1:0]   frameCount,
  output logic [NUM_OBJ-1:0] timeoutMask,
  output logic               overrun
);

  localparam int IDX_W = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_OBJ - 1);
  localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [NUM_OBJ-1:0] ONE_OBJ  = NUM_OBJ'(1'b1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_GAP    = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_s;
  logic                 vs_dly_r;
  logic [IDX_W-1:0]     idx_r;
  logic [IDX_W-1:0]     idx_s;
  logic [TMO_W-1:0]     tmo_r;
  logic [TMO_W-1:0]     tmo_s;
  logic                 start_s;
  logic                 ack_s;
  logic                 tmo_hit_s;
  logic                 done_s;
  logic                 last_s;
  logic [NUM_OBJ-1:0]   upd_req_s;
  logic                 commit_s;
  logic                 busy_s;
  logic [CNT_W-1:0]     frame_count_s;
  logic [NUM_OBJ-1:0]   timeout_mask_s;
  logic                 overrun_s;

  function automatic logic [NUM_OBJ-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = ONE_OBJ << i;
  endfunction

  // Handshake qualifiers; acks only count while a request is actually out.
  assign start_s   = vs_dly_r & ~vsync;
  assign ack_s     = (state_r == S_REQ) & updAck[idx_r];
  assign tmo_hit_s = (state_r == S_REQ) & (tmo_r == TMO_LAST) & ~ack_s;
  assign done_s    = ack_s | tmo_hit_s;
  assign last_s    = (idx_r == LAST_IDX);

  // State register.
  always_ff @(posedge real100clock) begin
    if (!resetN) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_s && enable) begin
          state_s = S_REQ;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_REQ: begin
        if (done_s) begin
          state_s = last_s ? S_COMMIT : S_GAP;
        end else begin
          state_s = S_REQ;
        end
      end
      S_GAP:    state_s = S_REQ;
      S_COMMIT: state_s = S_IDLE;
      default:  state_s = S_IDLE;
    endcase
  end

  // Next values of the datapath and registered outputs.
  always_comb begin
    idx_s         = idx_r;
    tmo_s         = tmo_r;
    upd_req_s     = updReq;
    commit_s      = 1'b0;
    busy_s        = busy;
    frame_count_s = frameCount;
    case (state_r)
      S_IDLE: begin
        if (start_s && enable) begin
          idx_s     = '0;
          tmo_s     = '0;
          upd_req_s = onehot('0);
          busy_s    = 1'b1;
        end else begin
          upd_req_s = '0;
          busy_s    = 1'b0;
        end
      end
      S_REQ: begin
        if (done_s) begin
          upd_req_s = '0;
          if (last_s) begin
            commit_s      = 1'b1;
            frame_count_s = frameCount + CNT_W'(1'b1);
          end else begin
            idx_s = idx_r + IDX_W'(1'b1);
          end
        end else begin
          tmo_s = tmo_r + TMO_W'(1'b1);
        end
      end
      S_GAP: begin
        tmo_s     = '0;
        upd_req_s = onehot(idx_r);
      end
      S_COMMIT: begin
        upd_req_s = '0;
        busy_s    = 1'b0;
      end
      default: begin
        upd_req_s = '0;
        busy_s    = 1'b0;
      end
    endcase

    // Sticky flags: a new event in the same cycle as clrFlags stays set.
    if (clrFlags) begin
      timeout_mask_s = '0;
    end else begin
      timeout_mask_s = timeoutMask;
    end
    if (tmo_hit_s) begin
      timeout_mask_s = timeout_mask_s | onehot(idx_r);
    end else begin
      timeout_mask_s = timeout_mask_s;
    end
    if (start_s && enable && (state_r != S_IDLE)) begin
      overrun_s = 1'b1;
    end else if (clrFlags) begin
      overrun_s = 1'b0;
    end else begin
      overrun_s = overrun;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge real100clock) begin
    if (!resetN) begin
      vs_dly_r    <= 1'b1;
      idx_r       <= '0;
      tmo_r       <= '0;
      updReq      <= '0;
      commit      <= 1'b0;
      busy        <= 1'b0;
      frameCount  <= '0;
      timeoutMask <= '0;
      overrun     <= 1'b0;
    end else begin
      vs_dly_r    <= vsync;
      idx_r       <= idx_s;
      tmo_r       <= tmo_s;
      updReq      <= upd_req_s;
      commit      <= commit_s;
      busy        <= busy_s;
      frameCount  <= frame_count_s;
      timeoutMask <= timeout_mask_s;
      overrun     <= overrun_s;
    end
  end

endmodule
